serial_tx_arbiter: RTL

Round-robin arbiter sharing one asynchronous serial transmitter among `NUM_REQ` requesters, each sending multi-word messages. It sits between the requesting blocks and the tx controller, and runs in the transmitter's serial clock domain. Once a requester is granted, it holds the transmitter for its whole message, terminated by `in_last`. The arbiter drives the transmitter's enable and parallel data, and returns per-word acknowledges to the owner.

---
 rtl/serial_arb_pkg.sv | 17 +
 rtl/serial_tx_arbiter_rr_pick.sv | 41 ++++
 rtl/serial_tx_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_arb_pkg
// Purpose  : Shared types for the serial transmitter arbiter.
//            t_arb_state - arbiter state machine encoding (Idle/Send/Drain).
// Revision : 1.0 - initial release
// ============================================================================
package serial_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2
   } t_arb_state;

endpackage : serial_arb_pkg
`default_nettype wire

// File: rtl/serial_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority picker. Returns the first
//            asserted request found searching from in_ptr upward, modulo
//            NUM_REQ.
// Ports    : in_req     - request vector
//            in_ptr     - index with highest priority this cycle
//            out_winner - index of the selected request
//            out_valid  - at least one request is asserted
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] in_req,
   input  logic [IDX_W-1:0]   in_ptr,
   output logic [IDX_W-1:0]   out_winner,
   output logic               out_valid
);

   int idx;

   // Walk the search order backwards so the nearest request to the pointer
   // is the last one written and therefore wins.
   always_comb begin
      out_winner = '0;
      out_valid  = 1'b0;
      idx        = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(in_ptr) + k) % NUM_REQ;
         if (in_req[idx]) begin
            out_winner = IDX_W'(idx);
            out_valid  = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Purpose  : Round-robin arbiter sharing one serial transmitter among
//            NUM_REQ requesters. An owner keeps the transmitter for a whole
//            message (up to in_last) unless it drops its request (abort).
// Ports    : serial_clk, in_rst        - serial bit clock, async high reset
//            in_req/in_last/in_data    - per-requester word interface
//            out_ack                   - word-consumed pulse to owner
//            out_grant                 - one-hot owner (registered)
//            out_busy, out_abort       - status
//            in_tx_ready/in_tx_next_word - transmitter status
//            out_tx_enable/out_tx_parallel - transmitter controls
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter
   import serial_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BITS    = 8
) (
   input  logic                    serial_clk,
   input  logic                    in_rst,
   input  logic [NUM_REQ-1:0]      in_req,
   input  logic [NUM_REQ-1:0]      in_last,
   input  logic [NUM_REQ*BITS-1:0] in_data,
   output logic [NUM_REQ-1:0]      out_ack,
   output logic [NUM_REQ-1:0]      out_grant,
   output logic                    out_busy,
   output logic                    out_abort,
   input  logic                    in_tx_ready,
   input  logic                    in_tx_next_word,
   output logic                    out_tx_enable,
   output logic [BITS-1:0]         out_tx_parallel
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   t_arb_state         state_q,     state_d;
   logic [IDX_W-1:0]   rr_q,        rr_d;
   logic [NUM_REQ-1:0] grant_q,     grant_d;
   logic               tx_enable_q, tx_enable_d;
   logic               abort_q,     abort_d;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;
   logic               owner_drop;
   logic               owner_last;
   logic               word_done;
   logic [BITS-1:0]    tx_parallel;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .in_req     (in_req),
      .in_ptr     (rr_q),
      .out_winner (pick_idx),
      .out_valid  (pick_valid)
   );

   // Owner status via the one-hot grant mask avoids a separate index flop.
   assign owner_drop = ~|(in_req & grant_q);
   assign owner_last = |(in_last & grant_q);
   // A dropped request takes priority over a coincident word strobe.
   assign word_done  = (state_q == ST_SEND) && in_tx_next_word && !owner_drop;

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      grant_d     = grant_q;
      tx_enable_d = tx_enable_q;
      abort_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_tx_ready && pick_valid) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               tx_enable_d       = 1'b1;
               rr_d              = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
               state_d           = ST_SEND;
            end
         end
         ST_SEND: begin
            if (owner_drop) begin
               abort_d     = 1'b1;
               tx_enable_d = 1'b0;
               state_d     = ST_DRAIN;
            end else if (in_tx_next_word && owner_last) begin
               tx_enable_d = 1'b0;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            tx_enable_d = 1'b0;
            if (in_tx_ready) begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            grant_d     = '0;
            tx_enable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge serial_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         grant_q     <= '0;
         tx_enable_q <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         grant_q     <= grant_d;
         tx_enable_q <= tx_enable_d;
         abort_q     <= abort_d;
      end
   end

   // Owner's data slice; OR-merge is exact because grant_q is one-hot or zero.
   always_comb begin
      tx_parallel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            tx_parallel = tx_parallel | in_data[i*BITS +: BITS];
         end
      end
   end

   assign out_ack         = word_done ? grant_q : '0;
   assign out_grant       = grant_q;
   assign out_busy        = (state_q != ST_IDLE);
   assign out_abort       = abort_q;
   assign out_tx_enable   = tx_enable_q;
   assign out_tx_parallel = tx_parallel;

endmodule : serial_tx_arbiter
`default_nettype wire
